// File: rtl/vga_frame_fetcher.sv
// -----------------------------------------------------------------------------
// vga_frame_fetcher
//
// Frame-level read controller for the VGA scan-out path. Each frame sync from
// the VGA output block starts a fetch of one RGB565 frame from the front
// framebuffer. The fetch is a sequence of fixed-length burst reads. The
// returned pixels pass through a small FIFO and go out on an AXI-Stream
// master port to the VGA block.
//
// Software requests front/back buffer swaps. A request is held pending and
// takes effect only when the next frame starts.
//
// Only one burst is outstanding at a time. A burst is requested only when the
// FIFO has room for all of its beats, so the FIFO can never overflow.
//
// Parameter constraints:
//   - H_PIXELS*V_LINES must be a multiple of BURST_LEN.
//   - The frame must hold at least two bursts.
//   - FIFO_DEPTH must be a power of two and >= 2*BURST_LEN.
//
// Ports:
//   i_Clock, i_Reset      clock; synchronous active-high reset
//   i_Frame_Sync          one-cycle frame start pulse from the VGA block
//   i_Fb_Base_0/1         byte base addresses of framebuffers 0 and 1
//   i_Swap_Request        pulse: flip the front buffer at the next frame start
//   o_Swap_Pending        a swap is latched but not yet applied
//   o_Front_Buffer        index of the framebuffer being scanned
//   o_Rd_Req_*            burst read request (valid/ready, byte addr, len-1)
//   i_Rd_Data_*           read data beats (no backpressure), last-beat flag
//   m_axis_*              pixel stream to the VGA block
//   o_Frame_Done          pulse when the final burst of a frame has returned
//   o_Late_Frame_Count    saturating count of syncs that arrived mid-fetch
// -----------------------------------------------------------------------------
module vga_frame_fetcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Frame_Sync,
    input  logic [ADDR_WIDTH-1:0] i_Fb_Base_0,
    input  logic [ADDR_WIDTH-1:0] i_Fb_Base_1,
    input  logic                  i_Swap_Request,
    output logic                  o_Swap_Pending,
    output logic                  o_Front_Buffer,
    output logic                  o_Rd_Req_Valid,
    input  logic                  i_Rd_Req_Ready,
    output logic [ADDR_WIDTH-1:0] o_Rd_Req_Addr,
    output logic [7:0]            o_Rd_Req_Len,
    input  logic                  i_Rd_Data_Valid,
    input  logic [15:0]           i_Rd_Data,
    input  logic                  i_Rd_Data_Last,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  o_Frame_Done,
    output logic [15:0]           o_Late_Frame_Count
);

    localparam int NUM_BURSTS = (H_PIXELS * V_LINES) / BURST_LEN;
    localparam int IDX_W      = $clog2(NUM_BURSTS + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [IDX_W-1:0]      LAST_BURST  = IDX_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(2 * BURST_LEN);
    // A burst may be requested only while occupancy is at or below this level.
    localparam logic [CNT_W-1:0]      CREDIT_MAX  = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [7:0]            REQ_LEN     = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DRAIN
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                  state_q;
    logic                    front_q;
    logic                    pending_q;
    logic                    req_valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [IDX_W-1:0]        burst_idx_q;
    logic                    done_q;
    logic [15:0]             late_q;

    logic [15:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    logic                    accept;
    logic                    beat_last;
    logic                    final_burst;
    logic                    start_frame;
    logic                    go_drain;
    logic                    late_sync;
    logic                    flush;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic                    new_front;
    logic [ADDR_WIDTH-1:0]   new_base;

    assign accept      = (state_q == ISSUE) && req_valid_q && i_Rd_Req_Ready;
    assign beat_last   = i_Rd_Data_Valid && i_Rd_Data_Last;
    assign final_burst = (burst_idx_q == LAST_BURST);

    // A new frame starts on a sync whenever no burst is left in flight.
    // A sync in ISSUE with nothing accepted qualifies. So does a sync on the
    // very beat that closes the current burst. The other way to start a frame
    // is the closing beat of a burst being drained after an early sync.
    assign start_frame = (i_Frame_Sync && ((state_q == IDLE) ||
                                           (state_q == ISSUE && !accept) ||
                                           (state_q == WAIT_DATA && beat_last)))
                       || ((state_q == DRAIN) && beat_last);

    // An early sync that leaves a burst still owed to us waits in DRAIN.
    assign go_drain  = i_Frame_Sync && (((state_q == ISSUE) && accept) ||
                                        ((state_q == WAIT_DATA) && !beat_last));

    assign late_sync = i_Frame_Sync && (state_q != IDLE);

    // Every sync flushes the FIFO; in DRAIN it is already empty.
    assign flush = i_Frame_Sync || start_frame;
    assign push  = (state_q == WAIT_DATA) && i_Rd_Data_Valid && !i_Frame_Sync;
    assign pop   = (count_q != '0) && m_axis_tready;

    // A pending swap takes effect at the frame start that consumes it.
    assign new_front = front_q ^ pending_q;
    assign new_base  = new_front ? i_Fb_Base_1 : i_Fb_Base_0;

    // NOTE: every signal assigned in always_comb gets a default first, so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // In ISSUE nothing is in flight. Occupancy can then only fall, so a
    // request that is already valid stays valid until it is accepted.
    assign credit_ok = (count_d <= CREDIT_MAX);

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            burst_idx_q <= '0;
            done_q      <= 1'b0;
            late_q      <= '0;
        end else begin
            done_q <= 1'b0;

            if (late_sync && (late_q != 16'hFFFF)) begin
                late_q <= late_q + 16'd1;
            end

            if (i_Swap_Request) begin
                pending_q <= 1'b1;
            end

            if (start_frame) begin
                // A request arriving on this edge is kept for the next frame.
                front_q     <= new_front;
                pending_q   <= i_Swap_Request;
                addr_q      <= new_base;
                len_q       <= REQ_LEN;
                burst_idx_q <= '0;
                req_valid_q <= credit_ok;
                state_q     <= ISSUE;
            end else if (go_drain) begin
                req_valid_q <= 1'b0;
                state_q     <= DRAIN;
            end else begin
                case (state_q)
                    ISSUE: begin
                        if (accept) begin
                            req_valid_q <= 1'b0;
                            state_q     <= WAIT_DATA;
                        end else begin
                            req_valid_q <= credit_ok;
                        end
                    end
                    WAIT_DATA: begin
                        if (beat_last) begin
                            burst_idx_q <= burst_idx_q + IDX_W'(1);
                            if (final_burst) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                addr_q      <= addr_q + BURST_BYTES;
                                req_valid_q <= credit_ok;
                                state_q     <= ISSUE;
                            end
                        end
                    end
                    default: begin
                        // IDLE waits for a sync; DRAIN waits for the last beat.
                        // Both exits are handled by start_frame above.
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Occupancy and pointers define
    // which entries are valid, and resetting the array would cost a reset
    // path on every bit.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_Rd_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_axis_tvalid      = (count_q != '0);
    // Data is forced to zero while empty so stale storage never shows up on
    // the bus, including straight after reset.
    assign m_axis_tdata       = m_axis_tvalid ? fifo_mem[rd_ptr_q] : 16'h0000;

    assign o_Swap_Pending     = pending_q;
    assign o_Front_Buffer     = front_q;
    assign o_Rd_Req_Valid     = req_valid_q;
    assign o_Rd_Req_Addr      = addr_q;
    assign o_Rd_Req_Len       = len_q;
    assign o_Frame_Done       = done_q;
    assign o_Late_Frame_Count = late_q;

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_fetcher
//
// Directed bench for vga_frame_fetcher. It uses a reduced frame of 16x8
// pixels, which gives 8 bursts of 16 beats.
//
// The memory model answers each accepted request one cycle later. It returns
// pixel value (addr/2 + beat) truncated to 16 bits. For the base addresses
// used here, pixel k of a frame therefore carries the value k.
// -----------------------------------------------------------------------------
module tb_vga_frame_fetcher;

    localparam int AW    = 32;
    localparam int HP    = 16;
    localparam int VL    = 8;
    localparam int BL    = 16;
    localparam int FD    = 32;
    localparam int TOTAL = HP * VL;
    localparam int NB    = TOTAL / BL;

    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0000;

    logic          i_Clock = 1'b0;
    logic          i_Reset;
    logic          i_Frame_Sync;
    logic [AW-1:0] i_Fb_Base_0;
    logic [AW-1:0] i_Fb_Base_1;
    logic          i_Swap_Request;
    logic          o_Swap_Pending;
    logic          o_Front_Buffer;
    logic          o_Rd_Req_Valid;
    logic          i_Rd_Req_Ready;
    logic [AW-1:0] o_Rd_Req_Addr;
    logic [7:0]    o_Rd_Req_Len;
    logic          i_Rd_Data_Valid;
    logic [15:0]   i_Rd_Data;
    logic          i_Rd_Data_Last;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          o_Frame_Done;
    logic [15:0]   o_Late_Frame_Count;

    vga_frame_fetcher #(
        .ADDR_WIDTH (AW),
        .H_PIXELS   (HP),
        .V_LINES    (VL),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Frame_Sync       (i_Frame_Sync),
        .i_Fb_Base_0        (i_Fb_Base_0),
        .i_Fb_Base_1        (i_Fb_Base_1),
        .i_Swap_Request     (i_Swap_Request),
        .o_Swap_Pending     (o_Swap_Pending),
        .o_Front_Buffer     (o_Front_Buffer),
        .o_Rd_Req_Valid     (o_Rd_Req_Valid),
        .i_Rd_Req_Ready     (i_Rd_Req_Ready),
        .o_Rd_Req_Addr      (o_Rd_Req_Addr),
        .o_Rd_Req_Len       (o_Rd_Req_Len),
        .i_Rd_Data_Valid    (i_Rd_Data_Valid),
        .i_Rd_Data          (i_Rd_Data),
        .i_Rd_Data_Last     (i_Rd_Data_Last),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .o_Frame_Done       (o_Frame_Done),
        .o_Late_Frame_Count (o_Late_Frame_Count)
    );

    initial begin
        forever #5 i_Clock = ~i_Clock;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          nacc;
    int          npix;
    int          ndone;
    logic [31:0] cur_base;
    logic [31:0] rsp_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Looks at the outputs at the current falling edge, then advances one
    // cycle. It tracks request addresses, pixel order and done pulses.
    task automatic sample();
        if (o_Rd_Req_Valid && i_Rd_Req_Ready) begin
            check("req_addr", o_Rd_Req_Addr, cur_base + 32'(2 * BL * nacc));
            check("req_len", 32'(o_Rd_Req_Len), 32'(BL - 1));
            nacc++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            check("pixel", 32'(m_axis_tdata), 32'(npix));
            npix++;
        end
        if (o_Frame_Done) begin
            ndone++;
        end
        @(negedge i_Clock);
    endtask

    task automatic pulse_sync(input logic [31:0] base, input logic swap);
        i_Frame_Sync   = 1'b1;
        i_Swap_Request = swap;
        cur_base       = base;
        nacc           = 0;
        npix           = 0;
        ndone          = 0;
        @(negedge i_Clock);
        i_Frame_Sync   = 1'b0;
        i_Swap_Request = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int cyc = 0;
        while (!(npix == TOTAL && ndone >= 1) && cyc < budget) begin
            sample();
            cyc++;
        end
        check({tag, "_pixels"}, 32'(npix), 32'(TOTAL));
        check({tag, "_done"}, 32'(ndone), 32'd1);
        check({tag, "_bursts"}, 32'(nacc), 32'(NB));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_valid"}, 32'(o_Rd_Req_Valid), 32'd0);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_front"}, 32'(o_Front_Buffer), 32'd0);
        check({tag, "_pending"}, 32'(o_Swap_Pending), 32'd0);
        check({tag, "_late"}, 32'(o_Late_Frame_Count), 32'd0);
        check({tag, "_done"}, 32'(o_Frame_Done), 32'd0);
    endtask

    // Memory model: a request accepted on one clock edge returns BL beats,
    // one per cycle, starting in the following cycle.
    initial begin
        i_Rd_Data_Valid = 1'b0;
        i_Rd_Data       = 16'h0000;
        i_Rd_Data_Last  = 1'b0;
        forever begin
            @(posedge i_Clock);
            if (o_Rd_Req_Valid && i_Rd_Req_Ready && !i_Reset) begin
                rsp_addr = o_Rd_Req_Addr;
                for (int b = 0; b < BL; b++) begin
                    @(negedge i_Clock);
                    i_Rd_Data_Valid = 1'b1;
                    i_Rd_Data       = 16'((rsp_addr >> 1) + 32'(b));
                    i_Rd_Data_Last  = (b == BL - 1);
                end
                @(negedge i_Clock);
                i_Rd_Data_Valid = 1'b0;
                i_Rd_Data_Last  = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        i_Reset        = 1'b1;
        i_Frame_Sync   = 1'b0;
        i_Swap_Request = 1'b0;
        i_Fb_Base_0    = BASE0;
        i_Fb_Base_1    = BASE1;
        i_Rd_Req_Ready = 1'b1;
        m_axis_tready  = 1'b1;
        nacc = 0; npix = 0; ndone = 0; cur_base = BASE0;
        repeat (2) @(negedge i_Clock);
        check_reset_state("rst");
        check("rst_addr", o_Rd_Req_Addr, 32'd0);
        check("rst_len", 32'(o_Rd_Req_Len), 32'd0);
        i_Reset = 1'b0;
        @(negedge i_Clock);

        // Full frame from buffer 0: request one cycle after sync, ordered pixels.
        pulse_sync(BASE0, 1'b0);
        check("t1_req_latency", 32'(o_Rd_Req_Valid), 32'd1);
        check("t1_first_addr", o_Rd_Req_Addr, BASE0);
        run_to_done("t1", 1000);
        check("t1_late", 32'(o_Late_Frame_Count), 32'd0);

        // Backpressure: two bursts fill the FIFO, then requests stop.
        m_axis_tready = 1'b0;
        pulse_sync(BASE0, 1'b0);
        repeat (120) sample();
        check("t2_bursts_held", 32'(nacc), 32'd2);
        check("t2_req_valid", 32'(o_Rd_Req_Valid), 32'd0);
        check("t2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t2_head", 32'(m_axis_tdata), 32'd0);
        m_axis_tready = 1'b1;
        run_to_done("t2", 1000);

        // Swap requested mid-frame; it is applied at the next sync.
        pulse_sync(BASE0, 1'b0);
        repeat (20) sample();
        i_Swap_Request = 1'b1;
        sample();
        i_Swap_Request = 1'b0;
        check("t3_pending_set", 32'(o_Swap_Pending), 32'd1);
        check("t3_front_hold", 32'(o_Front_Buffer), 32'd0);
        run_to_done("t3a", 1000);
        check("t3_pending_kept", 32'(o_Swap_Pending), 32'd1);
        pulse_sync(BASE1, 1'b0);
        check("t3_front_new", 32'(o_Front_Buffer), 32'd1);
        check("t3_pending_clr", 32'(o_Swap_Pending), 32'd0);
        run_to_done("t3b", 1000);

        // A request in the same cycle as the sync that applies a pending swap.
        i_Swap_Request = 1'b1;
        @(negedge i_Clock);
        i_Swap_Request = 1'b0;
        check("t4_pending_pre", 32'(o_Swap_Pending), 32'd1);
        pulse_sync(BASE0, 1'b1);
        check("t4_front", 32'(o_Front_Buffer), 32'd0);
        check("t4_pending", 32'(o_Swap_Pending), 32'd1);
        run_to_done("t4", 1000);

        // Early sync while burst 5 is returning: drain, flush, restart at base.
        pulse_sync(BASE1, 1'b0);
        check("t5_front", 32'(o_Front_Buffer), 32'd1);
        cyc = 0;
        while (nacc < 6 && cyc < 1000) begin
            sample();
            cyc++;
        end
        check("t5_reach_burst5", 32'(nacc), 32'd6);
        repeat (4) sample();
        pulse_sync(BASE1, 1'b0);
        check("t5_late", 32'(o_Late_Frame_Count), 32'd1);
        check("t5_flushed", 32'(m_axis_tvalid), 32'd0);
        check("t5_no_req_drain", 32'(o_Rd_Req_Valid), 32'd0);
        run_to_done("t5", 1000);
        check("t5_late_final", 32'(o_Late_Frame_Count), 32'd1);

        // Reset with ten entries queued: everything clears, late beats ignored.
        m_axis_tready = 1'b0;
        pulse_sync(BASE1, 1'b0);
        cyc = 0;
        while (nacc < 1 && cyc < 100) begin
            sample();
            cyc++;
        end
        repeat (10) sample();
        check("t6_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        check_reset_state("t6");
        nacc = 0;
        repeat (30) sample();
        check("t6_no_req", 32'(nacc), 32'd0);
        check("t6_tvalid_idle", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b1;

        // A request coinciding with a sync while nothing is pending is deferred.
        pulse_sync(BASE0, 1'b1);
        check("t7_front", 32'(o_Front_Buffer), 32'd0);
        check("t7_pending", 32'(o_Swap_Pending), 32'd1);
        run_to_done("t7", 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
